// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative mult/div unit: FSM state encoding,
// op codes and the iteration counter width helper.
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEFAULT_WIDTH = 32;

  // Bits needed to count WIDTH iterations (0 .. WIDTH-1), at least one.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bus between the main control FSM (master) and the
// mult/div sequencer (slave).
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the unsigned shift-add multiply or the
// restoring divide on a 2*WIDTH accumulator. For divide, the accumulator
// comes back shifted with a zero LSB; the caller inserts q_bit there.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               op,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_out,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  // Multiply adds into the upper half then shifts right with carry; divide
  // shifts left and keeps the trial subtraction when it does not go negative.
  always_comb begin
    sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
    trial   = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
    acc_out = '0;
    q_bit   = 1'b0;
    if (op == OP_MULT) begin
      acc_out = {sum, acc_in[WIDTH-1:1]};
    end else begin
      q_bit = ~trial[WIDTH];
      if (q_bit) begin
        acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end else begin
        acc_out = {acc_in[2*WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mult/div controller owning Hi/Lo. Operands are taken as
// magnitudes, iterated one bit per cycle, and sign-corrected in FIX.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      cnt;
  logic               op_r;
  logic               neg_lo;
  logic               neg_hi;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               div_zero_r;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               b_zero;
  logic               last_iter;

  assign a_mag     = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag     = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign b_zero    = (bus.b == '0);
  assign last_iter = (cnt == CW'(WIDTH - 1));

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_r),
    .acc_in  (acc),
    .operand (operand),
    .acc_out (step_acc),
    .q_bit   (step_q)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state: divide by zero short-circuits straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_DIV && b_zero) state_next = DONE;
          else if (bus.op == OP_DIV)      state_next = DIV;
          else                            state_next = MULT;
        end
      end
      MULT, DIV: if (last_iter) state_next = FIX;
      FIX:       state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Operand capture, iteration, sign fix-up and Hi/Lo write-back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      op_r       <= OP_MULT;
      neg_lo     <= 1'b0;
      neg_hi     <= 1'b0;
      operand    <= '0;
      acc        <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
      div_zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r       <= bus.op;
            operand    <= (bus.op == OP_DIV) ? b_mag : a_mag;
            acc        <= {{WIDTH{1'b0}}, ((bus.op == OP_DIV) ? a_mag : b_mag)};
            neg_lo     <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            neg_hi     <= (bus.op == OP_DIV) ? bus.a[WIDTH-1]
                                             : (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            div_zero_r <= (bus.op == OP_DIV) && b_zero;
            cnt        <= '0;
          end
        end
        MULT, DIV: begin
          acc <= {step_acc[2*WIDTH-1:1], (op_r == OP_DIV) ? step_q : step_acc[0]};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (op_r == OP_MULT) begin
            {hi_r, lo_r} <= neg_lo ? -acc : acc;
          end else begin
            lo_r <= neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            hi_r <= neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.div_zero = div_zero_r;
  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller and iterative datapath for the MIPS mult/div unit that owns the Hi/Lo registers.
- The main control FSM pulses start with op and operands, stalls while busy, and consumes the done pulse.
- Sequences a 1-bit-per-cycle signed shift-add multiply or restoring divide.
- Flags divide-by-zero so the main FSM can enter exception handling.

Parameters:
WIDTH, 32, operand width; hi/lo are WIDTH each, product is 2*WIDTH.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
op  input  1  0 = mult (signed), 1 = div (signed)
a  input  WIDTH  multiplicand / dividend (rs)
b  input  WIDTH  multiplier / divisor (rt)
busy  output  1  high from the cycle after start is accepted through DONE inclusive
done  output  1  one-cycle pulse; hi/lo (or div_zero) valid in that cycle
div_zero  output  1  high with done when a div had b == 0; cleared on next accepted start
hi  output  WIDTH  mult: upper product half; div: remainder
lo  output  WIDTH  mult: lower product half; div: quotient

Behaviour:
- Reset (async, active-high), from any state including mid-operation: state = IDLE, busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0, iteration counter = 0. The aborted operation is discarded.
- States: IDLE, MULT, DIV, FIX, DONE. Registered Moore outputs.
- IDLE:
  - start = 1 at edge T latches |a|, |b|, and sign flags (mult: sign(a) XOR sign(b); div: quotient sign = sign(a) XOR sign(b), remainder sign = sign(a)), clears div_zero, counter = 0.
  - If op = 1 and b == 0, go to DONE with div_zero = 1; hi/lo unchanged. done is visible at T+1.
  - Otherwise go to MULT (op = 0) or DIV (op = 1).
- MULT: WIDTH iterations, one per cycle. If the product LSB is set, add the multiplicand to the upper half, then shift the 2*WIDTH accumulator right. After the iteration with counter == WIDTH-1, go to FIX.
- DIV: WIDTH restoring iterations. Shift remainder:quotient left, trial-subtract divisor; if non-negative, keep the result and set quotient LSB = 1. After the iteration with counter == WIDTH-1, go to FIX.
- FIX:
  - Apply two's-complement negation per the sign flags.
  - Write hi/lo.
  - Go to DONE.
- DONE:
  - done = 1 for exactly one cycle, then return to IDLE.
  - A start in the DONE cycle is ignored.
- Latency for start accepted at edge T:
  - Iterations occupy T+1..T+WIDTH.
  - FIX at T+WIDTH+1.
  - done = 1 in cycle T+WIDTH+2 (T+34 for WIDTH = 32).
  - busy = 1 from T+1 through the DONE cycle.
- start while busy is ignored; no queuing.
- Changes to a/b after acceptance have no effect.
- Division semantics:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / -1 gives lo = 0x80000000, hi = 0; no overflow flag.
- Multiply 0x80000000 * 0x80000000: magnitudes are handled as unsigned WIDTH-bit values, so |0x80000000| = 2^31 is exact.
- hi/lo hold their last value between operations. They change only in FIX or on reset.

Decomposition:
- Shared package muldiv_pkg:
  - State encoding constants: IDLE = 0, MULT = 1, DIV = 2, FIX = 3, DONE = 4.
  - Op constants: OP_MULT = 0, OP_DIV = 1.
  - Counter width = clog2(WIDTH).
- Sub-module muldiv_step: combinational single iteration.
  - Inputs: op, accumulator, operand.
  - Output: next accumulator and quotient bit.
- FSM, counter, sign handling and output registers stay in muldiv_sequencer.

Test Plan:
- mult a = 7, b = 0xFFFFFFFD (-3), start at T -> busy from T+1, done at T+34, hi = 0xFFFFFFFF, lo = 0xFFFFFFEB, div_zero = 0.
- mult a = 0x80000000, b = 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
- div a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1); then div a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- div a = 5, b = 0 with hi/lo preloaded by a prior mult -> done and div_zero = 1 at T+1, busy = 1 at T+1 only, hi/lo unchanged; next accepted start clears div_zero.
- start re-pulsed at T+5 and T+34 during a mult -> ignored, single done at T+34, result matches the first operands even if a/b change at T+3.
- Reset asserted asynchronously at T+10 of a div -> busy, done, div_zero, hi, lo = 0 immediately; after release, a new mult 3*4 gives lo = 12, hi = 0 at the correct latency.
